// File: rtl/wr_abort_responder.sv
// Write-channel isolation and SLVERR abort responder for an AXI slave port.
// In PASS it forwards traffic and tracks outstanding write IDs. On a reset
// request it fences the slave, drains W bursts and answers every tracked
// write with an SLVERR B. It then pulses reset_clear_o toward the guard.

package wr_abort_responder_pkg;

    localparam int unsigned IdWidth   = 4;
    localparam int unsigned AddrWidth = 32;
    localparam int unsigned DataWidth = 32;

    typedef logic [IdWidth-1:0] id_t;

    typedef struct packed {
        id_t                  id;
        logic [AddrWidth-1:0] addr;
        logic [7:0]           len;
    } ax_chan_t;

    typedef struct packed {
        logic [DataWidth-1:0]   data;
        logic [DataWidth/8-1:0] strb;
        logic                   last;
    } w_chan_t;

    typedef struct packed {
        id_t        id;
        logic [1:0] resp;
    } b_chan_t;

    typedef struct packed {
        id_t                  id;
        logic [DataWidth-1:0] data;
        logic [1:0]           resp;
        logic                 last;
    } r_chan_t;

    typedef struct packed {
        ax_chan_t aw;
        logic     aw_valid;
        w_chan_t  w;
        logic     w_valid;
        logic     b_ready;
        ax_chan_t ar;
        logic     ar_valid;
        logic     r_ready;
    } req_t;

    typedef struct packed {
        logic    aw_ready;
        logic    w_ready;
        b_chan_t b;
        logic    b_valid;
        logic    ar_ready;
        r_chan_t r;
        logic    r_valid;
    } rsp_t;

endpackage

module wr_abort_responder #(
    parameter int unsigned MaxWrTxns = 32,
    parameter type         id_t      = wr_abort_responder_pkg::id_t,
    parameter type         req_t     = wr_abort_responder_pkg::req_t,
    parameter type         rsp_t     = wr_abort_responder_pkg::rsp_t,
    parameter int unsigned CntWidth  = 8
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  req_t                mst_req_i,
    output rsp_t                mst_rsp_o,
    output req_t                slv_req_o,
    input  rsp_t                slv_rsp_i,
    input  logic                reset_req_i,
    output logic                reset_clear_o,
    output logic                wr_en_o,
    output logic                isolated_o,
    output logic [CntWidth-1:0] abort_cnt_o
);

    localparam int unsigned IdxWidth = (MaxWrTxns > 1) ? $clog2(MaxWrTxns) : 1;

    typedef enum logic [2:0] {
        PASS    = 3'd0,
        ABORT_W = 3'd1,
        ABORT_B = 3'd2,
        CLEAR   = 3'd3,
        WAIT    = 3'd4
    } state_e;

    state_e                 state_q, state_d;
    logic [MaxWrTxns-1:0]   tab_valid_q;
    id_t                    tab_id_q [MaxWrTxns];
    logic [CntWidth-1:0]    pend_q, pend_d;
    logic [CntWidth-1:0]    abort_cnt_q, abort_cnt_d;

    logic                   free_found, low_found, match_found;
    logic [IdxWidth-1:0]    free_idx, low_idx, match_idx;
    logic                   alloc, free_b, abort_pop;
    logic                   aw_hs, w_last_hs, b_hs;

    // Priority search over the registered table: lowest free, lowest valid, lowest B-id match.
    always_comb begin
        free_found  = 1'b0;
        free_idx    = '0;
        low_found   = 1'b0;
        low_idx     = '0;
        match_found = 1'b0;
        match_idx   = '0;
        for (int unsigned i = 0; i < MaxWrTxns; i++) begin
            if (!tab_valid_q[i] && !free_found) begin
                free_found = 1'b1;
                free_idx   = IdxWidth'(i);
            end
            if (tab_valid_q[i] && !low_found) begin
                low_found = 1'b1;
                low_idx   = IdxWidth'(i);
            end
            if (tab_valid_q[i] && (tab_id_q[i] == slv_rsp_i.b.id) && !match_found) begin
                match_found = 1'b1;
                match_idx   = IdxWidth'(i);
            end
        end
    end

    // Next state, channel muxing and table/counter update requests.
    always_comb begin
        state_d     = state_q;
        pend_d      = pend_q;
        abort_cnt_d = abort_cnt_q;
        slv_req_o   = mst_req_i;
        mst_rsp_o   = slv_rsp_i;
        wr_en_o     = 1'b0;
        alloc       = 1'b0;
        free_b      = 1'b0;
        abort_pop   = 1'b0;
        aw_hs       = 1'b0;
        w_last_hs   = 1'b0;
        b_hs        = 1'b0;

        if (state_q != PASS) begin
            slv_req_o.aw_valid = 1'b0;
            slv_req_o.w_valid  = 1'b0;
            slv_req_o.ar_valid = 1'b0;
            slv_req_o.b_ready  = 1'b0;
            slv_req_o.r_ready  = 1'b0;
            mst_rsp_o.aw_ready = 1'b0;
            mst_rsp_o.w_ready  = 1'b0;
            mst_rsp_o.b_valid  = 1'b0;
            mst_rsp_o.ar_ready = 1'b0;
            mst_rsp_o.r_valid  = 1'b0;
        end

        unique case (state_q)
            PASS: begin
                slv_req_o.aw_valid = mst_req_i.aw_valid & free_found;
                mst_rsp_o.aw_ready = slv_rsp_i.aw_ready & free_found;
                aw_hs     = mst_req_i.aw_valid & slv_rsp_i.aw_ready & free_found;
                w_last_hs = mst_req_i.w_valid & slv_rsp_i.w_ready & mst_req_i.w.last;
                b_hs      = slv_rsp_i.b_valid & mst_req_i.b_ready;
                wr_en_o   = aw_hs;
                alloc     = aw_hs;
                free_b    = b_hs & match_found;
                // A stray last beat with nothing pending is forwarded but not counted.
                if (aw_hs && !(w_last_hs && (pend_q != '0))) begin
                    if (pend_q != '1) pend_d = pend_q + CntWidth'(1);
                end else if (!aw_hs && w_last_hs && (pend_q != '0)) begin
                    pend_d = pend_q - CntWidth'(1);
                end
                if (reset_req_i) state_d = ABORT_W;
            end
            ABORT_W: begin
                mst_rsp_o.w_ready = (pend_q != '0);
                if (mst_req_i.w_valid && (pend_q != '0) && mst_req_i.w.last) begin
                    pend_d = pend_q - CntWidth'(1);
                end
                if (pend_d == '0) state_d = ABORT_B;
            end
            ABORT_B: begin
                mst_rsp_o.b_valid = low_found;
                mst_rsp_o.b.id    = tab_id_q[low_idx];
                mst_rsp_o.b.resp  = 2'b10;
                abort_pop         = low_found & mst_req_i.b_ready;
                if (abort_pop && (abort_cnt_q != '1)) begin
                    abort_cnt_d = abort_cnt_q + CntWidth'(1);
                end
                if (!low_found) state_d = CLEAR;
            end
            CLEAR: begin
                state_d = WAIT;
            end
            WAIT: begin
                if (!reset_req_i) state_d = PASS;
            end
            default: begin
                state_d = PASS;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= PASS;
        end else begin
            state_q <= state_d;
        end
    end

    // Tracking table, pending-W and abort counters; allocation wins over a same-index free.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            tab_valid_q <= '0;
            for (int unsigned i = 0; i < MaxWrTxns; i++) tab_id_q[i] <= '0;
            pend_q      <= '0;
            abort_cnt_q <= '0;
        end else begin
            pend_q      <= pend_d;
            abort_cnt_q <= abort_cnt_d;
            if (free_b)    tab_valid_q[match_idx] <= 1'b0;
            if (abort_pop) tab_valid_q[low_idx]   <= 1'b0;
            if (alloc) begin
                tab_valid_q[free_idx] <= 1'b1;
                tab_id_q[free_idx]    <= mst_req_i.aw.id;
            end
        end
    end

    assign reset_clear_o = (state_q == CLEAR);
    assign isolated_o    = (state_q != PASS);
    assign abort_cnt_o   = abort_cnt_q;

endmodule

// File: tb/tb_wr_abort_responder.sv
// Bench for wr_abort_responder: directed scenarios plus random traffic,
// all checked cycle by cycle against a slot-table reference model.

module tb_wr_abort_responder;
    import wr_abort_responder_pkg::*;

    localparam int NSLOT = 32;
    localparam int PH_PASS = 0, PH_AW = 1, PH_AB = 2, PH_CLR = 3, PH_WAIT = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    req_t       mst_req, slv_req;
    rsp_t       mst_rsp, slv_rsp;
    logic       reset_req;
    logic       reset_clear, wr_en, isolated;
    logic [7:0] abort_cnt;

    int n_vec = 0;
    int n_err = 0;

    // Reference model: one slot per outstanding write, plus the drain phase.
    int ph;
    bit mv [NSLOT];
    int mid [NSLOT];
    int pend;
    int cnt;

    always #5 clk = ~clk;

    wr_abort_responder dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .mst_req_i    (mst_req),
        .mst_rsp_o    (mst_rsp),
        .slv_req_o    (slv_req),
        .slv_rsp_i    (slv_rsp),
        .reset_req_i  (reset_req),
        .reset_clear_o(reset_clear),
        .wr_en_o      (wr_en),
        .isolated_o   (isolated),
        .abort_cnt_o  (abort_cnt)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        ph = PH_PASS; pend = 0; cnt = 0;
        for (int i = 0; i < NSLOT; i++) begin mv[i] = 1'b0; mid[i] = 0; end
    endtask

    task automatic idle();
        mst_req = '0;
        slv_rsp = '0;
    endtask

    // One clock: check outputs at the falling edge, advance the model, return just after the rising edge.
    task automatic step();
        int  fi, mi, lo;
        bit  full, any, aw_hs, w_hs, b_hs;
        bit  e_awv, e_awr, e_wv, e_wr, e_bv, e_brdy, e_wren;
        @(negedge clk);
        fi = -1; mi = -1; lo = -1; full = 1'b1; any = 1'b0;
        for (int i = 0; i < NSLOT; i++) begin
            if (!mv[i]) begin
                full = 1'b0;
                if (fi < 0) fi = i;
            end else begin
                any = 1'b1;
                if (lo < 0) lo = i;
                if (mi < 0 && mid[i] == int'(slv_rsp.b.id)) mi = i;
            end
        end
        {e_awv, e_awr, e_wv, e_wr, e_bv, e_brdy, e_wren} = '0;
        {aw_hs, w_hs, b_hs} = '0;
        case (ph)
            PH_PASS: begin
                e_awv  = mst_req.aw_valid && !full;
                e_awr  = slv_rsp.aw_ready && !full;
                e_wv   = mst_req.w_valid;
                e_wr   = slv_rsp.w_ready;
                e_bv   = slv_rsp.b_valid;
                e_brdy = mst_req.b_ready;
                aw_hs  = mst_req.aw_valid && slv_rsp.aw_ready && !full;
                e_wren = aw_hs;
                w_hs   = mst_req.w_valid && slv_rsp.w_ready && mst_req.w.last;
                b_hs   = slv_rsp.b_valid && mst_req.b_ready;
            end
            PH_AW: begin
                e_wr = (pend != 0);
                w_hs = mst_req.w_valid && (pend != 0) && mst_req.w.last;
            end
            PH_AB:   e_bv = any;
            default: ;
        endcase
        check("isolated",    32'(isolated),         32'(ph != PH_PASS));
        check("reset_clear", 32'(reset_clear),      32'(ph == PH_CLR));
        check("abort_cnt",   32'(abort_cnt),        32'(cnt));
        check("wr_en",       32'(wr_en),            32'(e_wren));
        check("slv_aw_valid",32'(slv_req.aw_valid), 32'(e_awv));
        check("mst_aw_ready",32'(mst_rsp.aw_ready), 32'(e_awr));
        check("slv_w_valid", 32'(slv_req.w_valid),  32'(e_wv));
        check("mst_w_ready", 32'(mst_rsp.w_ready),  32'(e_wr));
        check("mst_b_valid", 32'(mst_rsp.b_valid),  32'(e_bv));
        check("slv_b_ready", 32'(slv_req.b_ready),  32'(e_brdy));
        if (ph == PH_AB && any) begin
            check("abort_b_id",   32'(mst_rsp.b.id),   32'(mid[lo]));
            check("abort_b_resp", 32'(mst_rsp.b.resp), 32'd2);
        end
        if (ph == PH_PASS) begin
            check("ar_passthru", 32'(slv_req.ar_valid), 32'(mst_req.ar_valid));
            if (e_bv) check("b_id_passthru", 32'(mst_rsp.b.id), 32'(slv_rsp.b.id));
        end
        case (ph)
            PH_PASS: begin
                if (b_hs && mi >= 0) mv[mi] = 1'b0;
                if (aw_hs) begin
                    mv[fi]  = 1'b1;
                    mid[fi] = int'(mst_req.aw.id);
                end
                if (aw_hs && !(w_hs && pend > 0)) pend = (pend < 255) ? pend + 1 : 255;
                else if (!aw_hs && w_hs && pend > 0) pend = pend - 1;
                if (reset_req) ph = PH_AW;
            end
            PH_AW: begin
                if (w_hs) pend = pend - 1;
                if (pend == 0) ph = PH_AB;
            end
            PH_AB: begin
                if (any && mst_req.b_ready) begin
                    mv[lo] = 1'b0;
                    if (cnt < 255) cnt = cnt + 1;
                end
                if (!any) ph = PH_CLR;
            end
            PH_CLR:  ph = PH_WAIT;
            default: if (!reset_req) ph = PH_PASS;
        endcase
        @(posedge clk);
        #1;
    endtask

    task automatic send_aw(input int id);
        idle();
        mst_req.aw_valid = 1'b1;
        mst_req.aw.id    = 4'(id);
        slv_rsp.aw_ready = 1'b1;
        step();
        idle();
    endtask

    // Raise the reset request, feed last beats and accept B until the guard may release.
    task automatic abort_and_release();
        idle();
        reset_req = 1'b1;
        step();
        mst_req.w_valid = 1'b1;
        mst_req.w.last  = 1'b1;
        mst_req.b_ready = 1'b1;
        for (int k = 0; k < 300 && ph != PH_WAIT; k++) step();
        check("abort_reached_wait", 32'(isolated), 32'd1);
        idle();
        step();
        reset_req = 1'b0;
        step();
        step();
        check("released_to_pass", 32'(isolated), 32'd0);
    endtask

    initial begin
        model_reset();
        idle();
        reset_req = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_isolated",    32'(isolated),    32'd0);
        check("rst_reset_clear", 32'(reset_clear), 32'd0);
        check("rst_abort_cnt",   32'(abort_cnt),   32'd0);
        check("rst_wr_en",       32'(wr_en),       32'd0);
        rst = 1'b0;
        step();

        // Single write id 3, burst of one beat, slave answers OKAY.
        send_aw(3);
        mst_req.w_valid = 1'b1; mst_req.w.last = 1'b1; slv_rsp.w_ready = 1'b1;
        step();
        idle();
        slv_rsp.b_valid = 1'b1; slv_rsp.b.id = 4'd3; mst_req.b_ready = 1'b1;
        step();
        idle();
        step();
        abort_and_release();

        // Three writes, only the first burst delivered before the abort.
        send_aw(1); send_aw(2); send_aw(1);
        mst_req.w_valid = 1'b1; mst_req.w.last = 1'b1; slv_rsp.w_ready = 1'b1;
        step();
        abort_and_release();

        // Fill every slot, try a 33rd, free slot 5 with a B, reuse it.
        for (int i = 0; i < NSLOT; i++) send_aw(i % 16);
        send_aw(12);
        slv_rsp.b_valid = 1'b1; slv_rsp.b.id = 4'd5; mst_req.b_ready = 1'b1;
        step();
        send_aw(9);
        abort_and_release();

        // Allocation and B free colliding in one cycle.
        send_aw(4);
        mst_req.aw_valid = 1'b1; mst_req.aw.id = 4'd7; slv_rsp.aw_ready = 1'b1;
        slv_rsp.b_valid = 1'b1; slv_rsp.b.id = 4'd4; mst_req.b_ready = 1'b1;
        step();
        abort_and_release();

        // Random traffic with occasional reset requests.
        for (int c = 0; c < 3000; c++) begin
            int nv;
            int vids [NSLOT];
            nv = 0;
            for (int i = 0; i < NSLOT; i++) if (mv[i]) begin vids[nv] = mid[i]; nv++; end
            mst_req = '0;
            slv_rsp = '0;
            mst_req.aw_valid = 1'($urandom_range(0, 1));
            mst_req.aw.id    = 4'($urandom_range(0, 7));
            mst_req.w_valid  = 1'($urandom_range(0, 1));
            mst_req.w.last   = ($urandom_range(0, 2) != 0);
            mst_req.b_ready  = ($urandom_range(0, 3) != 0);
            mst_req.ar_valid = 1'($urandom_range(0, 1));
            slv_rsp.aw_ready = ($urandom_range(0, 3) != 0);
            slv_rsp.w_ready  = ($urandom_range(0, 3) != 0);
            slv_rsp.b_valid  = ($urandom_range(0, 2) == 0);
            if (nv > 0 && $urandom_range(0, 3) != 0) slv_rsp.b.id = 4'(vids[$urandom_range(0, nv - 1)]);
            else slv_rsp.b.id = 4'($urandom_range(0, 15));
            if (ph == PH_PASS && $urandom_range(0, 59) == 0) reset_req = 1'b1;
            else if (ph == PH_WAIT && $urandom_range(0, 3) == 0) reset_req = 1'b0;
            step();
        end
        idle();
        reset_req = 1'b0;
        for (int k = 0; k < 300 && ph != PH_PASS; k++) begin
            mst_req.w_valid = 1'b1; mst_req.w.last = 1'b1; mst_req.b_ready = 1'b1;
            step();
        end
        idle();
        step();

        // Asynchronous reset in the middle of the SLVERR phase.
        send_aw(2); send_aw(3);
        reset_req = 1'b1;
        step();
        mst_req.w_valid = 1'b1; mst_req.w.last = 1'b1;
        for (int k = 0; k < 20 && ph != PH_AB; k++) step();
        idle();
        step();
        check("mid_abort_b_pending", 32'(mst_rsp.b_valid), 32'd1);
        #1 rst = 1'b1;
        #1;
        check("async_isolated",    32'(isolated),        32'd0);
        check("async_abort_cnt",   32'(abort_cnt),       32'd0);
        check("async_reset_clear", 32'(reset_clear),     32'd0);
        check("async_b_valid",     32'(mst_rsp.b_valid), 32'd0);
        check("async_wr_en",       32'(wr_en),           32'd0);
        reset_req = 1'b0;
        model_reset();
        #1 rst = 1'b0;
        step();
        send_aw(6);
        mst_req.w_valid = 1'b1; mst_req.w.last = 1'b1; slv_rsp.w_ready = 1'b1;
        step();
        idle();
        slv_rsp.b_valid = 1'b1; slv_rsp.b.id = 4'd6; mst_req.b_ready = 1'b1;
        step();
        idle();
        step();
        abort_and_release();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
